// File: rtl/frv_wb_arb.sv
// Two-master (instruction/data) to one-slave Wishbone classic arbiter with
// round-robin contention resolution, grant held until ack, and a bus timeout guard.
module frv_wb_arb #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADR_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             imem_cyc_i,
  input  logic             imem_stb_i,
  input  logic [ADR_W-1:0] imem_adr_i,
  output logic [31:0]      imem_dat_o,
  output logic             imem_ack_o,
  input  logic             dmem_cyc_i,
  input  logic             dmem_stb_i,
  input  logic             dmem_we_i,
  input  logic [3:0]       dmem_be_i,
  input  logic [ADR_W-1:0] dmem_adr_i,
  input  logic [31:0]      dmem_dat_i,
  output logic [31:0]      dmem_dat_o,
  output logic             dmem_ack_o,
  output logic             bus_cyc_o,
  output logic             bus_stb_o,
  output logic             bus_we_o,
  output logic [3:0]       bus_sel_o,
  output logic [ADR_W-1:0] bus_adr_o,
  output logic [31:0]      bus_dat_o,
  input  logic [31:0]      bus_dat_i,
  input  logic             bus_ack_i,
  output logic             timeout_o
);

  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t        state, state_nxt;
  logic          last_d, last_d_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          req_i, req_d;
  logic          gnt_cyc;
  logic          to_hit;

  assign req_i = imem_cyc_i & imem_stb_i;
  assign req_d = dmem_cyc_i & dmem_stb_i;

  always_comb begin
    gnt_cyc = 1'b0;
    case (state)
      GNT_I:   gnt_cyc = imem_cyc_i;
      GNT_D:   gnt_cyc = dmem_cyc_i;
      default: gnt_cyc = 1'b0;
    endcase
  end

  // A dropped cyc is an abort and wins over the timeout; a real ack wins over both.
  generate
    if (TIMEOUT > 0) begin : g_to
      assign to_hit = (state != IDLE) & gnt_cyc & ~bus_ack_i &
                      (tcnt == TW'(TIMEOUT - 1));
    end else begin : g_no_to
      assign to_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state  <= IDLE;
      last_d <= 1'b0;
      tcnt   <= '0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
      tcnt   <= tcnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    tcnt_nxt   = tcnt;
    case (state)
      IDLE: begin
        tcnt_nxt = '0;
        if (req_i && (!req_d || last_d)) state_nxt = GNT_I;
        else if (req_d)                  state_nxt = GNT_D;
      end
      GNT_I, GNT_D: begin
        if (bus_ack_i || !gnt_cyc || to_hit) begin
          state_nxt  = IDLE;
          last_d_nxt = (state == GNT_D);
          tcnt_nxt   = '0;
        end else if (TIMEOUT > 0) begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_cyc_o  = 1'b0;
    bus_stb_o  = 1'b0;
    bus_we_o   = 1'b0;
    bus_sel_o  = '0;
    bus_adr_o  = '0;
    bus_dat_o  = '0;
    imem_ack_o = 1'b0;
    dmem_ack_o = 1'b0;
    imem_dat_o = bus_dat_i;
    dmem_dat_o = bus_dat_i;
    timeout_o  = to_hit;
    case (state)
      GNT_I: begin
        bus_cyc_o  = imem_cyc_i;
        bus_stb_o  = imem_stb_i;
        bus_sel_o  = '1;
        bus_adr_o  = imem_adr_i;
        imem_ack_o = bus_ack_i | to_hit;
        if (to_hit) imem_dat_o = '0;
      end
      GNT_D: begin
        bus_cyc_o  = dmem_cyc_i;
        bus_stb_o  = dmem_stb_i;
        bus_we_o   = dmem_we_i;
        bus_sel_o  = dmem_be_i;
        bus_adr_o  = dmem_adr_i;
        bus_dat_o  = dmem_dat_i;
        dmem_ack_o = bus_ack_i | to_hit;
        if (to_hit) dmem_dat_o = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_frv_wb_arb.sv
// Self-checking bench for frv_wb_arb: directed scenarios with literal expectations
// plus randomized masters/slave checked every cycle against a transaction-level model.
module tb_frv_wb_arb;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_cyc_i, imem_stb_i;
  logic [31:0] imem_adr_i, imem_dat_o;
  logic        imem_ack_o;
  logic        dmem_cyc_i, dmem_stb_i, dmem_we_i;
  logic [3:0]  dmem_be_i;
  logic [31:0] dmem_adr_i, dmem_dat_i, dmem_dat_o;
  logic        dmem_ack_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_adr_o, bus_dat_o, bus_dat_i;
  logic        bus_ack_i, timeout_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  frv_wb_arb #(.TIMEOUT(TO), .ADR_W(32)) dut (
    .clk_i(clk), .rst_in(rst_n),
    .imem_cyc_i(imem_cyc_i), .imem_stb_i(imem_stb_i), .imem_adr_i(imem_adr_i),
    .imem_dat_o(imem_dat_o), .imem_ack_o(imem_ack_o),
    .dmem_cyc_i(dmem_cyc_i), .dmem_stb_i(dmem_stb_i), .dmem_we_i(dmem_we_i),
    .dmem_be_i(dmem_be_i), .dmem_adr_i(dmem_adr_i), .dmem_dat_i(dmem_dat_i),
    .dmem_dat_o(dmem_dat_o), .dmem_ack_o(dmem_ack_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_sel_o(bus_sel_o), .bus_adr_o(bus_adr_o), .bus_dat_o(bus_dat_o),
    .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i), .timeout_o(timeout_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the bus, how long the transaction has run,
  // and which master was served last.
  int m_owner;  // 0 none, 1 imem, 2 dmem
  int m_age;    // granted cycles already spent without completion
  bit m_last_d;

  function automatic bit owner_cyc();
    if (m_owner == 1) return imem_cyc_i;
    if (m_owner == 2) return dmem_cyc_i;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = 0; m_age = 0; m_last_d = 0;
    end else if (m_owner == 0) begin
      bit ri, rd;
      ri = imem_cyc_i && imem_stb_i;
      rd = dmem_cyc_i && dmem_stb_i;
      if (ri && rd) m_owner = m_last_d ? 1 : 2;
      else if (ri)  m_owner = 1;
      else if (rd)  m_owner = 2;
      m_age = 0;
    end else begin
      if (bus_ack_i || !owner_cyc() || (m_age + 1 == TO)) begin
        m_last_d = (m_owner == 2);
        m_owner  = 0;
        m_age    = 0;
      end else begin
        m_age++;
      end
    end
  end

  logic e_cyc, e_stb, e_we, e_iack, e_dack, e_to;
  logic [3:0]  e_sel;
  logic [31:0] e_adr, e_dat, e_idat, e_ddat;

  always @(negedge clk) begin
    e_cyc = 0; e_stb = 0; e_we = 0; e_sel = 0; e_adr = 0; e_dat = 0;
    e_iack = 0; e_dack = 0; e_idat = bus_dat_i; e_ddat = bus_dat_i;
    e_to = (m_owner != 0) && owner_cyc() && !bus_ack_i && (m_age + 1 == TO);
    if (m_owner == 1) begin
      e_cyc = imem_cyc_i; e_stb = imem_stb_i; e_sel = 4'hF; e_adr = imem_adr_i;
      e_iack = bus_ack_i || e_to;
      if (e_to) e_idat = 0;
    end else if (m_owner == 2) begin
      e_cyc = dmem_cyc_i; e_stb = dmem_stb_i; e_we = dmem_we_i; e_sel = dmem_be_i;
      e_adr = dmem_adr_i; e_dat = dmem_dat_i;
      e_dack = bus_ack_i || e_to;
      if (e_to) e_ddat = 0;
    end
    chk("m_cyc", bus_cyc_o, e_cyc);
    chk("m_stb", bus_stb_o, e_stb);
    chk("m_we", bus_we_o, e_we);
    chk("m_sel", bus_sel_o, e_sel);
    chk("m_adr", bus_adr_o, e_adr);
    chk("m_wdat", bus_dat_o, e_dat);
    chk("m_iack", imem_ack_o, e_iack);
    chk("m_dack", dmem_ack_o, e_dack);
    chk("m_to", timeout_o, e_to);
    if (e_iack) chk("m_idat", imem_dat_o, e_idat);
    if (e_dack) chk("m_ddat", dmem_dat_o, e_ddat);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_all();
    imem_cyc_i = 0; imem_stb_i = 0; dmem_cyc_i = 0; dmem_stb_i = 0;
    dmem_we_i = 0; bus_ack_i = 0;
    step();
    step();
  endtask

  bit ib, db;

  initial begin
    rst_n = 0;
    imem_cyc_i = 0; imem_stb_i = 0; imem_adr_i = 0;
    dmem_cyc_i = 0; dmem_stb_i = 0; dmem_we_i = 0; dmem_be_i = 0;
    dmem_adr_i = 0; dmem_dat_i = 0; bus_dat_i = 0; bus_ack_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", bus_cyc_o, 0);
    chk("rst_stb", bus_stb_o, 0);
    chk("rst_acks", {imem_ack_o, dmem_ack_o, timeout_o}, 0);
    step();
    rst_n = 1;
    step();

    // imem read
    imem_cyc_i = 1; imem_stb_i = 1; imem_adr_i = 32'h30;
    @(negedge clk); chk("t1_stb_req_cycle", bus_stb_o, 0);
    step(); @(negedge clk);
    chk("t1_stb", bus_stb_o, 1);
    chk("t1_sel", bus_sel_o, 4'hF);
    chk("t1_we", bus_we_o, 0);
    chk("t1_adr", bus_adr_o, 32'h30);
    chk("t1_model_owner", m_owner, 1);
    step(); @(negedge clk); chk("t1_noack", imem_ack_o, 0);
    step(); bus_ack_i = 1; bus_dat_i = 32'h13;
    @(negedge clk);
    chk("t1_iack", imem_ack_o, 1);
    chk("t1_idat", imem_dat_o, 32'h13);
    chk("t1_dack", dmem_ack_o, 0);
    step(); imem_cyc_i = 0; imem_stb_i = 0; bus_ack_i = 0;
    @(negedge clk); chk("t1_after", {bus_cyc_o, imem_ack_o}, 0);
    idle_all();

    // dmem write
    dmem_cyc_i = 1; dmem_stb_i = 1; dmem_we_i = 1; dmem_be_i = 4'b0011;
    dmem_adr_i = 32'h1000_0004; dmem_dat_i = 32'hA5A5_1234;
    step(); @(negedge clk);
    chk("t2_we", bus_we_o, 1);
    chk("t2_sel", bus_sel_o, 4'b0011);
    chk("t2_adr", bus_adr_o, 32'h1000_0004);
    chk("t2_dat", bus_dat_o, 32'hA5A5_1234);
    step(); bus_ack_i = 1;
    @(negedge clk); chk("t2_dack", dmem_ack_o, 1); chk("t2_iack", imem_ack_o, 0);
    idle_all();

    // round robin from reset: D, I, D, I with one idle cycle between
    rst_n = 0;
    imem_cyc_i = 1; imem_stb_i = 1; imem_adr_i = 32'h100;
    dmem_cyc_i = 1; dmem_stb_i = 1; dmem_we_i = 0; dmem_adr_i = 32'h200;
    bus_ack_i = 1;
    step(); rst_n = 1;
    @(negedge clk); chk("t3_k0", {imem_ack_o, dmem_ack_o, bus_cyc_o}, 0);
    for (int k = 1; k < 8; k++) begin
      step(); @(negedge clk);
      chk($sformatf("t3_dack_k%0d", k), dmem_ack_o, (k % 4) == 1);
      chk($sformatf("t3_iack_k%0d", k), imem_ack_o, (k % 4) == 3);
      chk($sformatf("t3_cyc_k%0d", k), bus_cyc_o, (k % 2) == 1);
    end
    idle_all();

    // timeout on dmem read, then ack landing exactly on the last cycle
    for (int rep = 0; rep < 2; rep++) begin
      dmem_cyc_i = 1; dmem_stb_i = 1; dmem_we_i = 0; dmem_adr_i = 32'h2000;
      bus_dat_i = 32'hDEAD_BEEF; bus_ack_i = 0;
      for (int g = 1; g <= TO; g++) begin
        step();
        if (rep == 1 && g == TO) bus_ack_i = 1;
        @(negedge clk);
        chk($sformatf("t4_r%0d_dack_g%0d", rep, g), dmem_ack_o, g == TO);
        chk($sformatf("t4_r%0d_to_g%0d", rep, g), timeout_o, (rep == 0) && (g == TO));
        if (g == TO)
          chk($sformatf("t4_r%0d_ddat", rep), dmem_dat_o, rep == 0 ? 32'h0 : 32'hDEAD_BEEF);
      end
      step(); dmem_cyc_i = 0; dmem_stb_i = 0; bus_ack_i = 0;
      @(negedge clk); chk($sformatf("t4_r%0d_idle", rep), {bus_cyc_o, timeout_o, dmem_ack_o}, 0);
      step();
    end
    idle_all();

    // imem abort: next cycle is IDLE even with a fresh request present
    imem_cyc_i = 1; imem_stb_i = 1; imem_adr_i = 32'h44;
    step(); @(negedge clk); chk("t5_gnt", bus_stb_o, 1);
    step(); imem_cyc_i = 0; imem_stb_i = 0;
    @(negedge clk); chk("t5_drop", {bus_cyc_o, imem_ack_o}, 0);
    step(); imem_cyc_i = 1; imem_stb_i = 1;
    @(negedge clk); chk("t5_idle", {bus_stb_o, imem_ack_o}, 0);
    step(); bus_ack_i = 1;
    @(negedge clk); chk("t5_regnt", imem_ack_o, 1);
    idle_all();

    // async reset mid dmem grant, then first contention goes to dmem
    dmem_cyc_i = 1; dmem_stb_i = 1; dmem_we_i = 1; dmem_be_i = 4'hF;
    dmem_adr_i = 32'h3000; dmem_dat_i = 32'h1;
    step(); @(negedge clk); chk("t6_gnt", bus_cyc_o, 1);
    #1 rst_n = 0;
    #1 chk("t6_async", {bus_cyc_o, bus_stb_o}, 0);
    imem_cyc_i = 1; imem_stb_i = 1; imem_adr_i = 32'h4000;
    step(); rst_n = 1;
    @(negedge clk); chk("t6_idle", bus_cyc_o, 0);
    step(); @(negedge clk);
    chk("t6_adr", bus_adr_o, 32'h3000);
    chk("t6_model_owner", m_owner, 2);
    step(); bus_ack_i = 1;
    @(negedge clk); chk("t6_dack", dmem_ack_o, 1);
    idle_all();

    // randomized traffic
    ib = 0; db = 0;
    repeat (3000) begin
      step();
      if (ib && e_iack) ib = 0;
      if (db && e_dack) db = 0;
      if (ib && $urandom_range(0, 63) == 0) ib = 0;
      if (db && $urandom_range(0, 63) == 0) db = 0;
      if (!ib && $urandom_range(0, 2) == 0) begin
        ib = 1; imem_adr_i = $urandom & 32'hFFFF_FFFC;
      end
      if (!db && $urandom_range(0, 2) == 0) begin
        db = 1; dmem_adr_i = $urandom & 32'hFFFF_FFFC; dmem_dat_i = $urandom;
        dmem_we_i = $urandom_range(0, 1); dmem_be_i = 4'($urandom);
      end
      imem_cyc_i = ib ? 1'b1 : ($urandom_range(0, 3) == 0);
      imem_stb_i = ib;
      dmem_cyc_i = db ? 1'b1 : ($urandom_range(0, 3) == 0);
      dmem_stb_i = db;
      bus_ack_i  = ($urandom_range(0, 3) == 0);
      bus_dat_i  = $urandom;
    end
    idle_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frv_wb_arb.md
Name: frv_wb_arb

Overview:
- Two-master to one-slave Wishbone (classic, non-pipelined) arbiter.
- Merges the instruction and data ports of a single-bus FazyRV core (frv_N macro) onto one shared memory bus.
- Round-robin fairness when both ports request; grant is held until slave ack; bus timeout guard so a dead slave cannot hang the core.
- Sits between the frv_N macro and the SoC memory/peripheral interconnect.

Parameters:
- TIMEOUT, 255, cycles in a granted state without slave ack before forced completion; 0 disables the timeout.
- ADR_W, 32, address width of all ports.

Ports:
- clk_i  in  1  clock
- rst_in  in  1  asynchronous reset, active low
- imem_cyc_i  in  1  instruction master cycle
- imem_stb_i  in  1  instruction master strobe
- imem_adr_i  in  ADR_W  instruction address
- imem_dat_o  out  32  instruction read data
- imem_ack_o  out  1  instruction ack
- dmem_cyc_i  in  1  data master cycle
- dmem_stb_i  in  1  data master strobe
- dmem_we_i  in  1  data write enable
- dmem_be_i  in  4  data byte enables
- dmem_adr_i  in  ADR_W  data address
- dmem_dat_i  in  32  data write data
- dmem_dat_o  out  32  data read data
- dmem_ack_o  out  1  data ack
- bus_cyc_o  out  1  shared bus cycle
- bus_stb_o  out  1  shared bus strobe
- bus_we_o  out  1  shared bus write enable
- bus_sel_o  out  4  shared bus byte select
- bus_adr_o  out  ADR_W  shared bus address
- bus_dat_o  out  32  shared bus write data
- bus_dat_i  in  32  shared bus read data
- bus_ack_i  in  1  shared bus ack
- timeout_o  out  1  one-cycle pulse on forced completion

Behaviour:
- Request: req_i = imem_cyc_i & imem_stb_i; req_d = dmem_cyc_i & dmem_stb_i.
- State register: IDLE, GNT_I, GNT_D. last_d (1 = dmem served last). Timeout counter tcnt, width clog2(TIMEOUT+1).
- Reset (async): state IDLE, last_d 0, tcnt 0. All bus_* control outputs 0, all acks 0, timeout_o 0. Outputs go low immediately on rst_in assertion, including mid-transaction.
- IDLE transitions:
  - only req_i -> GNT_I
  - only req_d -> GNT_D
  - both -> GNT_I if last_d = 1, else GNT_D (first contention after reset goes to dmem)
  - none -> stay IDLE
- Bus outputs are combinational from the registered state:
  - IDLE: bus_cyc_o = bus_stb_o = bus_we_o = 0; bus_sel_o, bus_adr_o, bus_dat_o = 0.
  - GNT_I: bus_cyc_o = imem_cyc_i, bus_stb_o = imem_stb_i, bus_we_o = 0, bus_sel_o = 4'hF, bus_adr_o = imem_adr_i, bus_dat_o = 0.
  - GNT_D: bus_cyc_o = dmem_cyc_i, bus_stb_o = dmem_stb_i, bus_we_o = dmem_we_i, bus_sel_o = dmem_be_i, bus_adr_o = dmem_adr_i, bus_dat_o = dmem_dat_i.
- Latency:
  - Request seen in cycle N -> bus_stb_o high in cycle N+1.
  - Ack path is combinational: imem_ack_o = (state == GNT_I) & bus_ack_i, likewise for dmem. The non-granted master's ack is always 0.
- Read data: imem_dat_o and dmem_dat_o both forward bus_dat_i, except on timeout completion where the completing master sees 32'h0. Data is only meaningful with ack.
- Completion: bus_ack_i in GNT_x -> IDLE next cycle; last_d <= (x == D); tcnt <= 0.
  - At least one IDLE cycle between transactions; a held request re-arbitrates then.
- Abort: granted master's cyc drops before ack -> IDLE next cycle, no ack, last_d updated as if served.
- Timeout (TIMEOUT > 0):
  - tcnt increments each granted cycle without ack.
  - When tcnt == TIMEOUT-1 and there is no ack: in that cycle assert the granted master's ack with data 0, pulse timeout_o, -> IDLE.
  - bus_ack_i in that same cycle takes precedence: normal completion, no timeout_o.
- Slave ack in IDLE is ignored and not forwarded.
- Masters must hold cyc/stb/adr/data stable until ack (Wishbone classic); the arbiter does not latch them.

Test Plan:
- Single imem read adr 0x30, slave acks 2 cycles after stb with 0x00000013 -> bus_stb_o rises 1 cycle after request, bus_sel_o = 4'hF, bus_we_o = 0, imem_ack_o 1 cycle with 0x00000013, dmem_ack_o stays 0.
- dmem write adr 0x1000_0004, be 4'b0011, dat 0xA5A5_1234 -> bus_we_o = 1, bus_sel_o = 4'b0011, bus fields match, dmem_ack_o forwarded.
- Both request continuously from reset, slave acks in 1 cycle -> grant order D, I, D, I, with exactly one IDLE cycle between grants.
- TIMEOUT = 4, slave never acks dmem read -> dmem_ack_o high in 4th granted cycle with dmem_dat_o = 0, timeout_o single pulse, then IDLE; repeat with ack on cycle 4 -> normal data, no timeout_o.
- imem drops cyc mid-grant -> IDLE next cycle with no ack; rst_in asserted mid-dmem grant -> bus_cyc_o/bus_stb_o low asynchronously, and after release the first contention goes to dmem.
